// File: rtl/isa_pkg.sv
// isa_pkg: instruction field widths, memory-format opcodes, loader states and error codes
package isa_pkg;
  localparam int OPC_W  = 4;
  localparam int REG_W  = 3;
  localparam int MADR_W = 4;
  localparam int INST_W = 13;
  localparam logic [OPC_W-1:0] OP_ST = 4'b1110;
  localparam logic [OPC_W-1:0] OP_LD = 4'b1111;
  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, READ, CHECK, DONE} ldr_state_t;
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
endpackage

// File: rtl/inst_pack.sv
// inst_pack: packs decoded fields into the 13-bit register or memory instruction format
module inst_pack
  import isa_pkg::*;
(
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic [MADR_W-1:0] i_adrr,
  input  logic [REG_W-1:0]  i_opa,
  input  logic [REG_W-1:0]  i_opb,
  input  logic [REG_W-1:0]  i_dest,
  output logic [INST_W-1:0] o_word
);
  always_comb o_word = (i_opcode == OP_ST || i_opcode == OP_LD) ? {i_opcode, i_adrr, 2'b00, i_dest}
                                                                : {i_opcode, i_opa, i_opb, i_dest};
endmodule

// File: rtl/prog_loader.sv
// prog_loader: writes packed instructions to instruction memory, reads each back and verifies it
module prog_loader
  import isa_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int INST_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_adrr,
  input  logic [2:0]        in_operanda,
  input  logic [2:0]        in_operandb,
  input  logic [2:0]        in_dest,
  input  logic              in_last,
  output logic              im_we,
  output logic [AW-1:0]     im_addr,
  output logic [INST_W-1:0] im_wdata,
  input  logic [INST_W-1:0] im_rdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error,
  output logic [AW:0]       count
);
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);
  ldr_state_t        r_state;
  logic              r_last;
  logic [INST_W-1:0] w_word;
  logic              w_full;
  inst_pack u_pack (
    .i_opcode (in_opcode),
    .i_adrr   (in_adrr),
    .i_opa    (in_operanda),
    .i_opb    (in_operandb),
    .i_dest   (in_dest),
    .o_word   (w_word)
  );
  // count doubles as the write pointer; it never wraps because overflow ends the session
  always_comb w_full = count == LAST_CNT;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last   <= 1'b0;
      in_ready <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= ERR_NONE;
      count    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state  <= ACCEPT;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          done     <= 1'b0;
          error    <= ERR_NONE;
          count    <= '0;
        end
        ACCEPT: if (in_valid) begin
          r_state  <= WRITE;
          in_ready <= 1'b0;
          im_we    <= 1'b1;
          im_addr  <= count[AW-1:0];
          im_wdata <= w_word;
          r_last   <= in_last;
        end
        WRITE: begin
          r_state <= READ;
          im_we   <= 1'b0;
        end
        READ: r_state <= CHECK;
        CHECK: if (im_rdata != im_wdata) begin
          r_state <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          error   <= ERR_MISMATCH;
        end else begin
          count <= count + 1'b1;
          if (r_last || w_full) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            error   <= r_last ? ERR_NONE : ERR_OVERFLOW;
          end else begin
            r_state  <= ACCEPT;
            in_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven packing checks plus scoreboarded multi-word, error and reset sequences
module tb_prog_loader;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready, in_last, im_we, busy, done;
  logic [3:0] in_opcode, in_adrr;
  logic [2:0] in_operanda, in_operandb, in_dest;
  logic [AW-1:0] im_addr;
  logic [12:0] im_wdata, im_rdata;
  logic [1:0] error;
  logic [AW:0] count;
  prog_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_adrr(in_adrr), .in_operanda(in_operanda), .in_operandb(in_operandb),
    .in_dest(in_dest), .in_last(in_last), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .im_rdata(im_rdata), .busy(busy), .done(done), .error(error), .count(count)
  );
  always #5 clk = ~clk;
  logic [12:0] mem [DEPTH];
  logic corrupt = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  always @(posedge clk) begin
    if (im_we) mem[im_addr] <= im_wdata;
    im_rdata <= mem[im_addr] ^ {12'b0, corrupt && im_addr == corrupt_addr};
  end
  typedef struct {logic [AW-1:0] addr; logic [12:0] word;} exp_t;
  typedef struct {logic [3:0] op; logic [3:0] adrr; logic [2:0] a; logic [2:0] b; logic [2:0] d; logic [12:0] word;} vec_t;
  exp_t sb[$];
  exp_t e;
  time we_t[$];
  int checks = 0;
  int errors = 0;
  int n_we = 0;
  int exp_addr = 0;
  int n0;
  vec_t vecs[6];
  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask
  function automatic logic [12:0] pack(logic [3:0] op, logic [3:0] adrr, logic [2:0] a, logic [2:0] b, logic [2:0] d);
    return (op == 4'b1110 || op == 4'b1111) ? {op, adrr, 2'b00, d} : {op, a, b, d};
  endfunction
  always @(negedge clk) if (im_we === 1'b1) begin
    n_we++;
    we_t.push_back($time);
    chk("in_ready_in_write", int'(in_ready), 0);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_we addr %0d data 0x%0h expected no write", im_addr, im_wdata);
    end else begin
      e = sb.pop_front();
      chk("we_addr", int'(im_addr), int'(e.addr));
      chk("we_data", int'(im_wdata), int'(e.word));
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = 0;
  endtask
  task automatic send(logic [3:0] op, logic [3:0] adrr, logic [2:0] a, logic [2:0] b, logic [2:0] d,
                      logic last, logic [12:0] word, bit keep);
    int n = 0;
    in_opcode = op; in_adrr = adrr; in_operanda = a; in_operandb = b; in_dest = d; in_last = last;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("handshake_timeout", 0, 1);
    end else begin
      sb.push_back('{addr: AW'(exp_addr), word: word});
      exp_addr++;
      tick();
      chk("ready_after_hs", int'(in_ready), 0);
    end
    if (!keep) in_valid = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("done_timeout", int'(done), 1);
  endtask
  task automatic check_zero(string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_im_we"}, int'(im_we), 0);
    chk({tag, "_im_addr"}, int'(im_addr), 0);
    chk({tag, "_im_wdata"}, int'(im_wdata), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_error"}, int'(error), 0);
    chk({tag, "_count"}, int'(count), 0);
  endtask
  initial begin
    vecs[0] = '{4'b0001, 4'b1010, 3'b001, 3'b010, 3'b011, 13'h0253};
    vecs[1] = '{4'b1111, 4'b1100, 3'b111, 3'b111, 3'b101, 13'h1F85};
    vecs[2] = '{4'b1110, 4'b0100, 3'b101, 3'b011, 3'b100, 13'h1C84};
    vecs[3] = '{4'b1101, 4'b1111, 3'b111, 3'b000, 3'b111, 13'h1BC7};
    vecs[4] = '{4'b0000, 4'b1111, 3'b000, 3'b000, 3'b000, 13'h0000};
    vecs[5] = '{4'b1111, 4'b0000, 3'b111, 3'b111, 3'b000, 13'h1E00};
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_opcode = '0; in_adrr = '0; in_operanda = '0; in_operandb = '0; in_dest = '0;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();
    chk("idle_no_ready", int'(in_ready), 0);
    foreach (vecs[i]) begin
      do_start();
      chk("start_ready", int'(in_ready), 1);
      chk("start_busy", int'(busy), 1);
      chk("start_count", int'(count), 0);
      chk("start_done", int'(done), 0);
      send(vecs[i].op, vecs[i].adrr, vecs[i].a, vecs[i].b, vecs[i].d, 1'b1, vecs[i].word, 1'b0);
      wait_done();
      chk("vec_count", int'(count), 1);
      chk("vec_error", int'(error), 0);
      chk("vec_busy", int'(busy), 0);
      chk("vec_ready", int'(in_ready), 0);
      chk("vec_sb_empty", sb.size(), 0);
    end
    do_start();
    we_t.delete();
    for (int i = 0; i < 3; i++) begin
      send(4'(i + 2), 4'(i), 3'(i), 3'(i + 1), 3'(i + 2), i == 2, pack(4'(i + 2), 4'(i), 3'(i), 3'(i + 1), 3'(i + 2)), 1'b1);
      tick();
      chk("multi_ready_read", int'(in_ready), 0);
      tick();
      chk("multi_ready_check", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    wait_done();
    chk("multi_count", int'(count), 3);
    chk("multi_error", int'(error), 0);
    chk("multi_writes", we_t.size(), 3);
    if (we_t.size() == 3) begin
      chk("multi_gap1", int'(we_t[1] - we_t[0]), 40);
      chk("multi_gap2", int'(we_t[2] - we_t[1]), 40);
    end
    corrupt = 1'b1;
    corrupt_addr = 4'd1;
    do_start();
    send(4'b0011, 4'd0, 3'd1, 3'd2, 3'd3, 1'b0, pack(4'b0011, 4'd0, 3'd1, 3'd2, 3'd3), 1'b0);
    send(4'b1111, 4'd9, 3'd0, 3'd0, 3'd6, 1'b0, pack(4'b1111, 4'd9, 3'd0, 3'd0, 3'd6), 1'b0);
    wait_done();
    chk("mism_error", int'(error), 1);
    chk("mism_count", int'(count), 1);
    n0 = n_we;
    in_valid = 1'b1;
    repeat (8) tick();
    chk("mism_no_write", n_we, n0);
    chk("mism_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    corrupt = 1'b0;
    do_start();
    for (int i = 0; i < DEPTH; i++)
      send(4'(i), 4'(15 - i), 3'(i), 3'(i + 3), 3'(i + 5), 1'b0, pack(4'(i), 4'(15 - i), 3'(i), 3'(i + 3), 3'(i + 5)), 1'b0);
    wait_done();
    chk("ovf_error", int'(error), 2);
    chk("ovf_count", int'(count), DEPTH);
    n0 = n_we;
    in_valid = 1'b1;
    repeat (8) tick();
    chk("ovf_no_17th", n_we, n0);
    chk("ovf_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    chk("ovf_sb_empty", sb.size(), 0);
    do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_accept_ready", int'(in_ready), 1);
    chk("start_in_accept_busy", int'(busy), 1);
    for (int i = 0; i < 3; i++)
      send(4'b0101, 4'd0, 3'(i), 3'(i), 3'(i), 1'b0, pack(4'b0101, 4'd0, 3'(i), 3'(i), 3'(i)), 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check_zero("midreset");
    n0 = n_we;
    reset = 1'b0;
    repeat (4) tick();
    chk("midreset_no_write", n_we, n0);
    do_start();
    chk("restart_addr", int'(im_addr), 0);
    chk("restart_count", int'(count), 0);
    send(4'b0001, 4'd0, 3'd1, 3'd2, 3'd3, 1'b1, 13'h0253, 1'b0);
    wait_done();
    chk("restart_final_count", int'(count), 1);
    chk("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
